// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter_if
//  Description : Signal bundle between the IF/MEM pipeline stages, the shared
//                single-port memory and the unified memory arbiter.
//                master = arbiter view, slave = pipeline + memory view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch requester
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_out;
    logic              inst_done;

    // MEM-stage (lw/sw) requester
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_done;

    // Single-port memory bus
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    // Pipeline stall / bubble controls
    logic              PcWrite;
    logic              IF_ID_Write;
    logic              IF_ID_Flush;
    logic              pipe_stall;

    modport master (
        input  inst_req, inst_addr,
        input  data_req, data_we, data_addr, data_wdata,
        input  mem_ready, mem_rdata,
        output inst_out, inst_done,
        output data_rdata, data_done,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output PcWrite, IF_ID_Write, IF_ID_Flush, pipe_stall
    );

    modport slave (
        output inst_req, inst_addr,
        output data_req, data_we, data_addr, data_wdata,
        output mem_ready, mem_rdata,
        input  inst_out, inst_done,
        input  data_rdata, data_done,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  PcWrite, IF_ID_Write, IF_ID_Flush, pipe_stall
    );
endinterface
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter
//  Description : Shares one single-port memory between instruction fetch and
//                the MEM stage. Non-preemptive IDLE/FETCH/DATA FSM with data
//                priority, a one-word instruction buffer for fetches that
//                complete while the pipeline is frozen, and the resulting
//                PC / IF-ID / pipeline stall controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    unified_mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t            state_q,      state_d;
    logic              mem_req_q,    mem_req_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              ibuf_valid_q, ibuf_valid_d;
    logic [DATA_W-1:0] ibuf_q,       ibuf_d;

    logic w_fetch_cpl;
    logic w_data_cpl;
    logic w_inst_done;
    logic w_data_done;
    logic w_fetch_stall;
    logic w_data_stall;
    logic w_pc_write;
    logic w_decide;
    logic w_grant_data;
    logic w_grant_inst;

    // Completion, stall and grant terms shared by the FSM and the outputs
    always_comb begin
        w_fetch_cpl   = (state_q == FETCH) && bus.mem_ready;
        w_data_cpl    = (state_q == DATA)  && bus.mem_ready;

        // A buffered instruction keeps IF satisfied until the PC can move.
        w_inst_done   = w_fetch_cpl || ibuf_valid_q;
        w_data_done   = w_data_cpl;

        w_fetch_stall = bus.inst_req && !w_inst_done;
        w_data_stall  = bus.data_req && !w_data_done;
        w_pc_write    = !(w_fetch_stall || w_data_stall);

        // Decisions are taken when idle or on the ready cycle of the current
        // access (back-to-back). Any state other than FETCH/DATA is treated
        // as idle so an illegal encoding recovers on the next decision.
        w_decide      = ((state_q != FETCH) && (state_q != DATA))
                        || w_fetch_cpl || w_data_cpl;

        // The requester completing this cycle still holds its request, so it
        // must not be granted again.
        w_grant_data  = w_decide && bus.data_req && !w_data_done;
        w_grant_inst  = w_decide && !w_grant_data && bus.inst_req
                        && !ibuf_valid_q && !w_inst_done;
    end

    // State and memory-bus registers; reset abandons any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state: grant on a decision point, otherwise hold the access stable
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (w_grant_data) begin
            // Data is the older instruction, so it wins any tie.
            state_d     = DATA;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.data_we;
            mem_addr_d  = bus.data_addr;
            mem_wdata_d = bus.data_wdata;
        end else if (w_grant_inst) begin
            state_d     = FETCH;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.inst_addr;
        end else if (w_decide) begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
        end
    end

    // Instruction buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ibuf_valid_q <= 1'b0;
            ibuf_q       <= '0;
        end else begin
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_q       <= ibuf_d;
        end
    end

    // Capture a fetched word the frozen pipeline cannot take yet; release it
    // on the first cycle the PC advances
    always_comb begin
        ibuf_valid_d = ibuf_valid_q;
        ibuf_d       = ibuf_q;
        if (w_fetch_cpl && !w_pc_write) begin
            ibuf_valid_d = 1'b1;
            ibuf_d       = bus.mem_rdata;
        end else if (ibuf_valid_q && w_pc_write) begin
            ibuf_valid_d = 1'b0;
        end
    end

    // Requester responses: buffered word first, else memory pass-through
    assign bus.inst_out    = ibuf_valid_q ? ibuf_q : bus.mem_rdata;
    assign bus.inst_done   = w_inst_done;
    assign bus.data_rdata  = bus.mem_rdata;
    assign bus.data_done   = w_data_done;

    // Registered memory bus
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;

    // Pipeline controls: a data wait freezes everything; a fetch-only wait
    // lets the back end drain and feeds a bubble into ID
    assign bus.pipe_stall  = w_data_stall;
    assign bus.PcWrite     = w_pc_write;
    assign bus.IF_ID_Write = w_pc_write;
    assign bus.IF_ID_Flush = w_fetch_stall && !w_data_stall;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unified_mem_arbiter
//  Description : Self-checking bench for unified_mem_arbiter: a control-output
//                vector table, a latency-programmable memory model and an
//                access scoreboard, plus hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h8C08_0004;
            32'h0000_0100: return 32'h0000_0055;
            default:       return a ^ 32'h1357_9BDF;
        endcase
    endfunction

    int lat = 1;       // cycles mem_req is high up to and including ready
    int wait_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst)                              wait_cnt <= 0;
        else if (bus.mem_req && !bus.mem_ready) wait_cnt <= wait_cnt + 1;
        else                                  wait_cnt <= 0;
    end

    assign bus.mem_ready = bus.mem_req && (wait_cnt == lat - 1);
    assign bus.mem_rdata = bus.mem_ready ? rdata_of(bus.mem_addr) : 32'hBAD0_BAD0;

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } acc_t;

    acc_t sb[$];

    task automatic expect_acc(input bit is_data, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        acc_t e;
        e.is_data = is_data;
        e.we      = we;
        e.addr    = addr;
        e.wdata   = wdata;
        e.rdata   = rdata_of(addr);
        sb.push_back(e);
    endtask

    // Every active memory cycle must match the oldest outstanding request;
    // the ready cycle also checks the requester response and retires it.
    always @(negedge clk) begin : mon
        acc_t e;
        if (!rst && bus.mem_req) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_access", 64'(sb.size()), 64'd1);
            end else begin
                e = sb[0];
                chk("sb_mem_addr", bus.mem_addr, e.addr);
                chk("sb_mem_we", bus.mem_we, e.we);
                if (e.we) chk("sb_mem_wdata", bus.mem_wdata, e.wdata);
                if (bus.mem_ready) begin
                    void'(sb.pop_front());
                    if (e.is_data) begin
                        chk("sb_data_done", bus.data_done, 1);
                        if (!e.we) chk("sb_data_rdata", bus.data_rdata, e.rdata);
                    end else begin
                        chk("sb_inst_done", bus.inst_done, 1);
                        chk("sb_inst_out", bus.inst_out, e.rdata);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc;   // drive point: just after the rising edge
        @(posedge clk);
        #1;
    endtask

    task automatic smp;   // sample point: falling edge
        @(negedge clk);
    endtask

    function automatic logic [3:0] ctrl();
        return {bus.PcWrite, bus.IF_ID_Write, bus.IF_ID_Flush, bus.pipe_stall};
    endfunction

    typedef struct {
        logic       ir;
        logic       dr;
        logic [3:0] exp;   // {PcWrite, IF_ID_Write, IF_ID_Flush, pipe_stall}
    } vec_t;

    vec_t vt[4];

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int dd_cnt;

        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;

        // ---- reset state ----
        smp;
        chk("rst_during_mem_req", bus.mem_req, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        smp;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_ctrl", ctrl(), 4'b1100);
        chk("rst_inst_done", bus.inst_done, 0);
        chk("rst_data_done", bus.data_done, 0);

        // ---- stall equations from IDLE (requests withdrawn before the edge) ----
        vt[0] = '{ir: 1'b0, dr: 1'b0, exp: 4'b1100};
        vt[1] = '{ir: 1'b1, dr: 1'b0, exp: 4'b0010};
        vt[2] = '{ir: 1'b0, dr: 1'b1, exp: 4'b0001};
        vt[3] = '{ir: 1'b1, dr: 1'b1, exp: 4'b0001};
        for (int i = 0; i < 4; i++) begin
            cyc;
            bus.inst_req  = vt[i].ir;
            bus.data_req  = vt[i].dr;
            bus.inst_addr = 32'h1000;
            bus.data_addr = 32'h2000;
            smp;
            chk($sformatf("vec%0d_ctrl", i), ctrl(), vt[i].exp);
            #1;
            bus.inst_req = 1'b0;
            bus.data_req = 1'b0;
        end
        smp;
        chk("vec_no_grant", bus.mem_req, 0);

        // ---- fetch only, 1-cycle memory ----
        lat = 1;
        cyc;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h40;
        expect_acc(1'b0, 1'b0, 32'h40, 32'h0);
        smp;
        chk("t1_c0_mem_req", bus.mem_req, 0);
        chk("t1_c0_flush", bus.IF_ID_Flush, 1);
        chk("t1_c0_pcwrite", bus.PcWrite, 0);
        cyc; smp;
        chk("t1_c1_mem_req", bus.mem_req, 1);
        chk("t1_c1_mem_addr", bus.mem_addr, 32'h40);
        chk("t1_c1_inst_done", bus.inst_done, 1);
        chk("t1_c1_inst_out", bus.inst_out, 32'h8C08_0004);
        chk("t1_c1_ctrl", ctrl(), 4'b1100);
        cyc;
        bus.inst_req = 1'b0;
        smp;
        chk("t1_c2_mem_req", bus.mem_req, 0);

        // ---- simultaneous requests: data first, fetch back-to-back ----
        lat = 2;
        cyc;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h300;
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h100;
        expect_acc(1'b1, 1'b0, 32'h100, 32'h0);
        expect_acc(1'b0, 1'b0, 32'h300, 32'h0);
        smp;
        chk("t2_c0_ctrl", ctrl(), 4'b0001);
        cyc; smp;
        chk("t2_c1_mem_addr", bus.mem_addr, 32'h100);
        chk("t2_c1_stall", bus.pipe_stall, 1);
        chk("t2_c1_data_done", bus.data_done, 0);
        cyc; smp;
        chk("t2_c2_data_done", bus.data_done, 1);
        chk("t2_c2_data_rdata", bus.data_rdata, 32'h55);
        chk("t2_c2_ctrl", ctrl(), 4'b0010);
        cyc;
        bus.data_req = 1'b0;
        smp;
        chk("t2_c3_mem_req", bus.mem_req, 1);
        chk("t2_c3_mem_addr", bus.mem_addr, 32'h300);
        cyc; smp;
        chk("t2_c4_inst_done", bus.inst_done, 1);
        chk("t2_c4_pcwrite", bus.PcWrite, 1);
        cyc;
        bus.inst_req = 1'b0;
        smp;
        chk("t2_c5_mem_req", bus.mem_req, 0);

        // ---- load arriving during a 3-cycle fetch ----
        lat = 3;
        cyc;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h80;
        expect_acc(1'b0, 1'b0, 32'h80, 32'h0);
        smp;
        cyc;
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h140;
        expect_acc(1'b1, 1'b0, 32'h140, 32'h0);
        smp;
        chk("t3_c1_ctrl", ctrl(), 4'b0001);
        cyc; smp;
        chk("t3_c2_inst_done", bus.inst_done, 0);
        cyc; smp;
        chk("t3_c3_inst_done", bus.inst_done, 1);
        chk("t3_c3_pcwrite", bus.PcWrite, 0);
        cyc; smp;
        chk("t3_c4_mem_addr", bus.mem_addr, 32'h140);
        chk("t3_c4_ibuf_done", bus.inst_done, 1);
        chk("t3_c4_ibuf_out", bus.inst_out, rdata_of(32'h80));
        chk("t3_c4_pcwrite", bus.PcWrite, 0);
        cyc; smp;
        cyc; smp;
        chk("t3_c6_data_done", bus.data_done, 1);
        chk("t3_c6_inst_done", bus.inst_done, 1);
        chk("t3_c6_inst_out", bus.inst_out, rdata_of(32'h80));
        chk("t3_c6_pcwrite", bus.PcWrite, 1);
        cyc;
        bus.data_req  = 1'b0;
        bus.inst_addr = 32'h84;
        expect_acc(1'b0, 1'b0, 32'h84, 32'h0);
        smp;
        chk("t3_c7_ibuf_cleared", bus.inst_done, 0);
        chk("t3_c7_no_refetch", bus.mem_req, 0);
        chk("t3_c7_flush", bus.IF_ID_Flush, 1);
        cyc; smp;
        chk("t3_c8_mem_addr", bus.mem_addr, 32'h84);
        cyc; smp;
        cyc; smp;
        cyc;
        bus.inst_req = 1'b0;
        smp;
        chk("t3_end_mem_req", bus.mem_req, 0);

        // ---- store held across 4 wait cycles ----
        lat = 5;
        cyc;
        bus.data_req = 1'b1; bus.data_we = 1'b1;
        bus.data_addr = 32'h200; bus.data_wdata = 32'hDEAD_BEEF;
        expect_acc(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
        smp;
        dd_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc;
            if (k == 6) begin
                bus.data_req = 1'b0;
                bus.data_we  = 1'b0;
            end
            smp;
            if (bus.data_done) dd_cnt++;
            if (k <= 4) begin
                chk($sformatf("t4_w%0d_mem_we", k), bus.mem_we, 1);
                chk($sformatf("t4_w%0d_mem_wdata", k), bus.mem_wdata, 32'hDEAD_BEEF);
            end
        end
        chk("t4_data_done_pulses", 64'(dd_cnt), 64'd1);

        // ---- requester address changes while waiting ----
        lat = 4;
        cyc;
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h180;
        expect_acc(1'b1, 1'b0, 32'h180, 32'h0);
        smp;
        for (int k = 1; k <= 4; k++) begin
            cyc;
            if (k == 2) bus.data_addr = 32'h1C0;
            if (k == 3) bus.data_addr = 32'h1E0;
            smp;
            chk($sformatf("t5_c%0d_addr_hold", k), bus.mem_addr, 32'h180);
        end
        cyc;
        bus.data_req = 1'b0;
        smp;
        chk("t5_end_mem_req", bus.mem_req, 0);

        // ---- reset in the middle of a data access ----
        lat = 6;
        cyc;
        bus.data_req = 1'b1; bus.data_addr = 32'h240;
        expect_acc(1'b1, 1'b0, 32'h240, 32'h0);
        smp;
        cyc; smp;
        cyc;
        chk("t6_pre_rst_mem_req", bus.mem_req, 1);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("t6_async_mem_req", bus.mem_req, 0);
        bus.data_req = 1'b0;
        cyc;
        cyc;
        rst = 1'b0;
        smp;
        chk("t6_post_ctrl", ctrl(), 4'b1100);
        chk("t6_post_mem_req", bus.mem_req, 0);
        chk("t6_post_mem_addr", bus.mem_addr, 0);
        chk("t6_post_done", {bus.inst_done, bus.data_done}, 2'b00);
        lat = 1;
        cyc;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h44;
        expect_acc(1'b0, 1'b0, 32'h44, 32'h0);
        smp;
        chk("t6_f_c0_mem_req", bus.mem_req, 0);
        cyc; smp;
        chk("t6_f_c1_mem_req", bus.mem_req, 1);
        chk("t6_f_c1_inst_out", bus.inst_out, rdata_of(32'h44));
        cyc;
        bus.inst_req = 1'b0;
        smp;

        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port memory between the IF stage (instruction fetch, read-only) and the MEM stage (lw/sw).
- Serialises the two requesters through a non-preemptive FSM.
- Buffers a fetched instruction while the pipeline is frozen.
- Generates the pipeline stall/bubble controls, alongside the hazard unit's PcWrite/IF_ID_Write.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory word width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
inst_req  in  1  IF wants an instruction; held until inst_done
inst_addr  in  ADDR_W  PC
inst_out  out  DATA_W  fetched instruction, valid when inst_done
inst_done  out  1  instruction available this cycle
data_req  in  1  MEM stage has lw/sw; held until data_done
data_we  in  1  1 = store
data_addr  in  ADDR_W  ALU result
data_wdata  in  DATA_W  store data
data_rdata  out  DATA_W  load data, valid when data_done
data_done  out  1  data access completes this cycle
mem_req  out  1  memory request, registered
mem_we  out  1  registered
mem_addr  out  ADDR_W  registered
mem_wdata  out  DATA_W  registered
mem_ready  in  1  memory completes the current request this cycle
mem_rdata  in  DATA_W  valid with mem_ready
PcWrite  out  1  0 = hold PC
IF_ID_Write  out  1  0 = hold IF/ID
IF_ID_Flush  out  1  1 = load bubble (nop) into IF/ID
pipe_stall  out  1  1 = freeze ID/EX, EX/MEM, MEM/WB

Behaviour:
- States: IDLE, FETCH, DATA.
- Grant decision:
  - Made in IDLE, and in FETCH/DATA on the mem_ready cycle (back-to-back).
  - data_req has priority; it is the older instruction.
  - inst_req is granted only if ibuf_valid=0 and inst_done is not already asserted this cycle.
  - No request → IDLE.
- On grant: register mem_addr, mem_we (0 for fetch), mem_wdata; set mem_req=1 next cycle. Minimum access time is 2 cycles (grant, then ready).
- In FETCH/DATA: mem_req and the latched address are held stable until mem_ready. No preemption.
- Fetch completion:
  - FETCH & mem_ready → inst_out=mem_rdata, inst_done=1 the same cycle.
  - If PcWrite=0 that cycle, the word is latched into ibuf and ibuf_valid is set.
  - While ibuf_valid=1: inst_done=1 and inst_out=ibuf.
  - ibuf_valid clears on the first cycle with PcWrite=1.
- Data completion: DATA & mem_ready → data_done=1 and data_rdata=mem_rdata, one cycle, combinational pass-through.
- Stall terms:
  - fetch_stall = inst_req & ~inst_done
  - data_stall = data_req & ~data_done
- Stall outputs:
  - pipe_stall = data_stall
  - PcWrite = IF_ID_Write = ~(fetch_stall | data_stall)
  - IF_ID_Flush = fetch_stall & ~data_stall. The pipeline advances and a bubble enters ID.
- Requester addresses are sampled only at grant. Changes while waiting are ignored.
- Simultaneous requests from IDLE: DATA first, then FETCH on the DATA mem_ready cycle.
- data_req arriving mid-FETCH: waits for the fetch to finish. The fetched word goes to ibuf, since PcWrite=0.
- A store completes on mem_ready. data_rdata is don't-care for stores.
- Reset, at any time including mid-access:
  - state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ibuf_valid=0, ibuf=0.
  - The in-flight request is abandoned.
  - Combinational outputs then follow their equations; with no requests: PcWrite=1, IF_ID_Write=1, IF_ID_Flush=0, pipe_stall=0, inst_done=0, data_done=0.

Test Plan:
- Fetch only. inst_req=1, inst_addr=0x40, memory returns 0x8C080004 with 1-cycle latency. Required:
  - mem_req rises cycle 1 with mem_addr=0x40.
  - inst_done=1 in cycle 1 with inst_out=0x8C080004.
  - IF_ID_Flush=1 in cycle 0; PcWrite=1 in cycle 1.
- Simultaneous requests. inst_req and data_req (load, addr 0x100, rdata 0x55) both asserted in cycle 0. Required:
  - DATA granted first: mem_addr=0x100, then data_done=1.
  - Next access is FETCH, back-to-back on the ready cycle.
  - pipe_stall=1 until data_done.
- Load during fetch. data_req rises while FETCH waits on a 3-cycle memory. Required:
  - Fetch completes and the word is captured in ibuf (PcWrite=0).
  - DATA then runs; inst_done stays 1 from the buffer.
  - ibuf_valid clears on the cycle data_done allows PcWrite=1.
  - No refetch of the same address occurs.
- Store. data_we=1, addr 0x200, wdata 0xDEADBEEF. Required:
  - mem_we=1, mem_wdata=0xDEADBEEF, held stable across 4 wait cycles.
  - data_done pulses exactly 1 cycle.
- Reset mid-access. rst asserted during DATA with mem_req=1. Required:
  - mem_req=0 immediately, without waiting for a clock edge.
  - After release with no requests: PcWrite=1, pipe_stall=0, state IDLE.
  - A fresh fetch then proceeds normally.
- Address change while waiting. data_addr changes during DATA wait states. Required: mem_addr keeps the value sampled at grant.
